// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared types and constants for the run-time clock divider controller
package clk_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_e;

  localparam int MIN_DIV   = 2;
  localparam int DEF_DIV_W = 8;

endpackage

// File: rtl/clk_div_core.sv
// rtl/clk_div_core.sv - period counter with registered divided-clock level and period tick
module clk_div_core
  import clk_div_pkg::*;
#(
  parameter int DIV_W = DEF_DIV_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_run,
  input  logic             i_run_nxt,
  input  logic [DIV_W-1:0] i_div_cur,
  input  logic [DIV_W-1:0] i_div_nxt,
  output logic             o_boundary,
  output logic             o_div_clk,
  output logic             o_div_tick
);

  logic [DIV_W-1:0] r_cnt;
  logic             r_div_clk;
  logic             r_div_tick;
  logic [DIV_W-1:0] w_cnt_nxt;
  logic             w_boundary;

  // Leaving IDLE restarts at 0 because the counter is parked there.
  always_comb begin
    w_boundary = i_run && (r_cnt == (i_div_cur - DIV_W'(1)));
    w_cnt_nxt  = (!i_run || w_boundary) ? '0 : r_cnt + DIV_W'(1);
  end

  // Outputs are registered from next-cycle values so they line up with r_cnt.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_div_clk  <= 1'b0;
      r_div_tick <= 1'b0;
    end else begin
      r_cnt      <= i_run_nxt ? w_cnt_nxt : '0;
      r_div_clk  <= i_run_nxt && (w_cnt_nxt >= (i_div_nxt >> 1));
      r_div_tick <= i_run_nxt && (w_cnt_nxt == '0);
    end
  end

  assign o_boundary = w_boundary;
  assign o_div_clk  = r_div_clk;
  assign o_div_tick = r_div_tick;

endmodule

// File: rtl/clk_div_ctrl.sv
// rtl/clk_div_ctrl.sv - divider FSM, ratio handshake and status; CLK_DIV_CTRL_RECFG_CNT_EN adds recfg_cnt
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int DIV_W   = DEF_DIV_W,
  parameter int DEF_DIV = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             div_clk,
  output logic             div_tick,
  output logic [DIV_W-1:0] cur_div,
  output logic             busy
`ifdef CLK_DIV_CTRL_RECFG_CNT_EN
  ,
  output logic [7:0]       recfg_cnt
`endif
);

  state_e           r_state;
  logic [DIV_W-1:0] r_cur_div;
  logic [DIV_W-1:0] r_pend_div;
  logic             r_cfg_ready;
  logic             r_cfg_err;
  logic             r_busy;

  state_e           w_state_nxt;
  logic [DIV_W-1:0] w_div_nxt;
  logic [DIV_W-1:0] w_pend_nxt;
  logic             w_apply;
  logic             w_xfer;
  logic             w_legal;
  logic             w_boundary;
  logic             w_run;
  logic             w_run_nxt;

  assign w_xfer    = cfg_valid && r_cfg_ready;
  assign w_legal   = (cfg_div >= DIV_W'(MIN_DIV));
  assign w_run     = (r_state != IDLE);
  assign w_run_nxt = (w_state_nxt != IDLE);

  always_comb begin
    w_state_nxt = r_state;
    w_div_nxt   = r_cur_div;
    w_pend_nxt  = r_pend_div;
    w_apply     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_xfer && w_legal) begin
          w_div_nxt = cfg_div;
          w_apply   = 1'b1;
        end
        if (en) w_state_nxt = RUN;
      end
      RUN: begin
        if (w_boundary) begin
          w_state_nxt = en ? RUN : IDLE;
          if (w_xfer && w_legal) begin
            w_div_nxt = cfg_div;
            w_apply   = 1'b1;
          end
        end else if (w_xfer && w_legal) begin
          w_pend_nxt  = cfg_div;
          w_state_nxt = PEND;
        end
      end
      PEND: begin
        if (w_boundary) begin
          w_div_nxt   = r_pend_div;
          w_apply     = 1'b1;
          w_state_nxt = en ? RUN : IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cur_div   <= DIV_W'(DEF_DIV);
      r_pend_div  <= '0;
      r_cfg_ready <= 1'b1;
      r_cfg_err   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cur_div   <= w_div_nxt;
      r_pend_div  <= w_pend_nxt;
      r_cfg_ready <= (w_state_nxt != PEND);
      r_cfg_err   <= w_xfer && !w_legal;
      r_busy      <= w_run_nxt;
    end
  end

`ifdef CLK_DIV_CTRL_RECFG_CNT_EN
  logic [7:0] r_recfg_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_recfg_cnt <= 8'd0;
    end else if (w_apply) begin
      r_recfg_cnt <= r_recfg_cnt + 8'd1;
    end
  end

  assign recfg_cnt = r_recfg_cnt;
`else
  logic w_apply_unused;
  assign w_apply_unused = w_apply;
`endif

  clk_div_core #(
    .DIV_W(DIV_W)
  ) u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_run     (w_run),
    .i_run_nxt (w_run_nxt),
    .i_div_cur (r_cur_div),
    .i_div_nxt (w_div_nxt),
    .o_boundary(w_boundary),
    .o_div_clk (div_clk),
    .o_div_tick(div_tick)
  );

  assign cfg_ready = r_cfg_ready;
  assign cfg_err   = r_cfg_err;
  assign cur_div   = r_cur_div;
  assign busy      = r_busy;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb/tb_clk_div_ctrl.sv - directed self-checking bench for clk_div_ctrl
module tb_clk_div_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       cfg_valid;
  logic [7:0] cfg_div;
  logic       cfg_ready;
  logic       cfg_err;
  logic       div_clk;
  logic       div_tick;
  logic [7:0] cur_div;
  logic       busy;
`ifdef CLK_DIV_CTRL_RECFG_CNT_EN
  logic [7:0] recfg_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  clk_div_ctrl #(
    .DIV_W  (8),
    .DEF_DIV(3)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .cfg_valid(cfg_valid),
    .cfg_div  (cfg_div),
    .cfg_ready(cfg_ready),
    .cfg_err  (cfg_err),
    .div_clk  (div_clk),
    .div_tick (div_tick),
    .cur_div  (cur_div),
    .busy     (busy)
`ifdef CLK_DIV_CTRL_RECFG_CNT_EN
    ,
    .recfg_cnt(recfg_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_out(input string tag, input logic exp_clk, input logic exp_tick,
                         input logic exp_busy, input logic exp_ready, input logic [7:0] exp_div);
    chk({tag, ".div_clk"}, div_clk, exp_clk);
    chk({tag, ".div_tick"}, div_tick, exp_tick);
    chk({tag, ".busy"}, busy, exp_busy);
    chk({tag, ".cfg_ready"}, cfg_ready, exp_ready);
    chk({tag, ".cur_div"}, cur_div, exp_div);
  endtask

  task automatic chk_reset(input string tag);
    chk_out(tag, 1'b0, 1'b0, 1'b0, 1'b1, 8'd3);
    chk({tag, ".cfg_err"}, cfg_err, 1'b0);
`ifdef CLK_DIV_CTRL_RECFG_CNT_EN
    chk({tag, ".recfg_cnt"}, recfg_cnt, 8'd0);
`endif
  endtask

  initial begin
    logic [5:0] pat3;
    logic [5:0] pat6;
    rst_n     = 1'b0;
    en        = 1'b0;
    cfg_valid = 1'b0;
    cfg_div   = 8'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset("reset");

    // D=3: div_clk 0,1,1 with tick on the 0 cycle
    rst_n = 1'b1;
    en    = 1'b1;
    pat3  = 6'b011011;
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk_out($sformatf("d3[%0d]", i), pat3[5-i], (i % 3) == 0, 1'b1, 1'b1, 8'd3);
    end

    // ratio 6 offered at cnt=0 goes pending until the D=3 period ends
    cyc();
    chk_out("d3.cnt0", 1'b0, 1'b1, 1'b1, 1'b1, 8'd3);
    cfg_valid = 1'b1;
    cfg_div   = 8'd6;
    cyc();
    cfg_valid = 1'b0;
    chk_out("pend.cnt1", 1'b1, 1'b0, 1'b1, 1'b0, 8'd3);
    cyc();
    chk_out("pend.cnt2", 1'b1, 1'b0, 1'b1, 1'b0, 8'd3);
    pat6 = 6'b000111;
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk_out($sformatf("d6[%0d]", i), pat6[5-i], i == 0, 1'b1, 1'b1, 8'd6);
    end

    // ratio 4 on the boundary cycle applies directly with no pending state
    cfg_valid = 1'b1;
    cfg_div   = 8'd4;
    cyc();
    cfg_valid = 1'b0;
    chk_out("d4[0]", 1'b0, 1'b1, 1'b1, 1'b1, 8'd4);
    cyc();
    chk_out("d4[1]", 1'b0, 1'b0, 1'b1, 1'b1, 8'd4);
    cyc();
    chk_out("d4[2]", 1'b1, 1'b0, 1'b1, 1'b1, 8'd4);
    cyc();
    chk_out("d4[3]", 1'b1, 1'b0, 1'b1, 1'b1, 8'd4);

    // illegal ratios 1 and 0 are accepted, flagged and dropped
    cfg_valid = 1'b1;
    cfg_div   = 8'd1;
    cyc();
    cfg_valid = 1'b0;
    chk("ill1.err", cfg_err, 1'b1);
    chk_out("ill1.c0", 1'b0, 1'b1, 1'b1, 1'b1, 8'd4);
    cyc();
    chk("ill1.err_clr", cfg_err, 1'b0);
    chk_out("ill1.c1", 1'b0, 1'b0, 1'b1, 1'b1, 8'd4);
    cfg_valid = 1'b1;
    cfg_div   = 8'd0;
    cyc();
    cfg_valid = 1'b0;
    chk("ill0.err", cfg_err, 1'b1);
    chk_out("ill0.c2", 1'b1, 1'b0, 1'b1, 1'b1, 8'd4);
    cyc();
    chk("ill0.err_clr", cfg_err, 1'b0);
    chk_out("ill0.c3", 1'b1, 1'b0, 1'b1, 1'b1, 8'd4);

    // switch to D=5 on the boundary, then drop en at cnt=1
    cfg_valid = 1'b1;
    cfg_div   = 8'd5;
    cyc();
    cfg_valid = 1'b0;
    chk_out("d5[0]", 1'b0, 1'b1, 1'b1, 1'b1, 8'd5);
`ifdef CLK_DIV_CTRL_RECFG_CNT_EN
    chk("recfg_cnt", recfg_cnt, 8'd3);
`endif
    cyc();
    chk_out("d5[1]", 1'b0, 1'b0, 1'b1, 1'b1, 8'd5);
    en = 1'b0;
    cyc();
    chk_out("stop[2]", 1'b1, 1'b0, 1'b1, 1'b1, 8'd5);
    cyc();
    chk_out("stop[3]", 1'b1, 1'b0, 1'b1, 1'b1, 8'd5);
    cyc();
    chk_out("stop[4]", 1'b1, 1'b0, 1'b1, 1'b1, 8'd5);
    cyc();
    chk_out("idle0", 1'b0, 1'b0, 1'b0, 1'b1, 8'd5);
    cyc();
    chk_out("idle1", 1'b0, 1'b0, 1'b0, 1'b1, 8'd5);
    en = 1'b1;
    cyc();
    chk_out("restart", 1'b0, 1'b1, 1'b1, 1'b1, 8'd5);

    // reset while a ratio is pending discards it
    cfg_valid = 1'b1;
    cfg_div   = 8'd7;
    cyc();
    cfg_valid = 1'b0;
    chk_out("pend7", 1'b0, 1'b0, 1'b1, 1'b0, 8'd5);
    rst_n = 1'b0;
    cyc();
    chk_reset("reset_pend");
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) cyc();
    chk_out("post_reset", 1'b1, 1'b0, 1'b1, 1'b1, 8'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clk_div_ctrl.md
Name: clk_div_ctrl

Overview:
Run-time controller for the integer clock divider. It owns the divide ratio and starts and stops division on request. It accepts new ratios over a valid/ready handshake and applies them only at a period boundary, so the divided output never produces a runt or truncated period. It produces a divided-clock level for observation and enable use, a one-cycle period tick for downstream enable-gated logic, and status for the configuration master.

Parameters:
DIV_W, 8, width of the divide-ratio field and the internal counter
DEF_DIV, 3, divide ratio loaded at reset; must be >= 2

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
en  in  1  1 = run divider, 0 = stop at the next period boundary
cfg_valid  in  1  new ratio offered
cfg_div  in  DIV_W  offered ratio D
cfg_ready  out  1  controller can accept a ratio
cfg_err  out  1  one-cycle pulse: the accepted ratio was illegal (D < 2) and was dropped
div_clk  out  1  divided clock level, registered
div_tick  out  1  one-cycle pulse in the first cycle of every divided period, registered
cur_div  out  DIV_W  ratio currently in effect
busy  out  1  state != IDLE

Behaviour:
- Clock and reset: single clock `clk`. Reset is synchronous and active-low on `rst_n`, sampled at the `clk` rising edge.
- Reset values:
  - state = IDLE, cnt = 0, cur_div = DEF_DIV, pending register cleared.
  - div_clk = 0, div_tick = 0, cfg_err = 0, busy = 0, cfg_ready = 1.
- Reset mid-operation discards any pending ratio.
- Counter: cnt runs 0 .. cur_div-1, then wraps to 0. The boundary cycle is cnt == cur_div-1.
- Output timing (all registered): in every RUN/PEND cycle,
  - div_clk = (cnt >= cur_div>>1). Low phase is floor(D/2) cycles; high phase is ceil(D/2) cycles.
  - div_tick = (cnt == 0).
  - In IDLE: div_clk = 0, div_tick = 0, cnt held at 0.
- States:
  - IDLE:
    - en = 1 → RUN next cycle, with cnt = 0 and div_tick = 1 in that first RUN cycle.
    - An accepted legal ratio loads cur_div on the next cycle.
  - RUN:
    - An accepted legal ratio is stored in pend_div → PEND.
    - Exception: if acceptance coincides with the boundary cycle, the ratio is applied at that boundary directly and the state stays RUN.
    - At a boundary with en = 0 → IDLE.
  - PEND:
    - At the boundary: cur_div <= pend_div, cnt <= 0, → RUN, or → IDLE if en = 0 (the ratio is still applied).
- Handshake:
  - cfg_ready = 1 in IDLE and RUN, 0 in PEND.
  - Transfer happens when cfg_valid & cfg_ready.
  - cfg_div is sampled only on a transfer.
- Illegal ratio (cfg_div < 2): the transfer completes and cfg_err pulses the following cycle. cur_div, state and the period are unaffected.
- Stopping: en deassertion mid-period finishes the current period before entering IDLE. A period is never truncated.
- en re-asserted before the boundary: stays RUN, no gap.
- Ratio change: the old period always completes at the old ratio. The new period begins with div_tick = 1 and cnt = 0.
- Maximum ratio is 2^DIV_W - 1. There is no counter overflow, since the wrap compare is done at DIV_W width.

Optional Feature:
Macro CLK_DIV_CTRL_RECFG_CNT_EN.
- Defined: adds output port recfg_cnt (8 bits, reset 0). It increments by 1 each cycle a new ratio actually takes effect in cur_div (from IDLE load, direct boundary apply, or PEND apply). It wraps 255 → 0. Illegal ratios do not count.
- Undefined: the port and its register are absent. All other behaviour is identical.

Decomposition:
- Package clk_div_pkg holds:
  - state enum (IDLE, RUN, PEND), 2 bits;
  - localparam MIN_DIV = 2;
  - default DIV_W value.
- One sub-module: clk_div_core. It contains the counter plus div_clk/div_tick generation, takes cur_div and a run/restart control, and exports the boundary flag. clk_div_ctrl holds the FSM, handshake and ratio registers.

Test Plan:
- Reset then en = 1, DEF_DIV = 3 → div_clk repeats 0,1,1. div_tick is high on each 0 cycle. busy = 1 from the first RUN cycle.
- RUN at D = 3, transfer cfg_div = 6 at cnt = 0 → cfg_ready = 0 for 2 cycles. Then div_clk is 0,0,0,1,1,1 and cur_div = 6 from the next period on. No period is shorter than 3.
- Transfer cfg_div = 4 exactly on a boundary cycle → no PEND state, cfg_ready stays 1, next period is 0,0,1,1.
- Transfer cfg_div = 1 in RUN → cfg_err pulses once next cycle, cur_div unchanged, pattern unchanged. Repeat with cfg_div = 0 → same result.
- en dropped at cnt = 1 of D = 5 → 3 more RUN cycles, then IDLE with div_clk = 0 and busy = 0. en re-raised → first RUN cycle has div_tick = 1.
- rst_n low during PEND → all reset values next cycle and cur_div = DEF_DIV. With CLK_DIV_CTRL_RECFG_CNT_EN: after 3 legal changes and 1 illegal change, recfg_cnt = 3.
